bcd_serial_alu: RTL

//  Parametrised digit-serial BCD add/subtract unit for the calculator datapath.

---
 rtl/bcd_serial_alu_if.sv | 26 ++
 rtl/bcd_serial_alu.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/bcd_serial_alu_if.sv
// Handshake/operand bundle for the digit-serial BCD add/subtract unit.
// master: requester (drives start/sub/a/b); slave: the ALU.
interface bcd_serial_alu_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic                  sub;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   result;
  logic                  neg;
  logic                  carry_out;
  logic                  invalid;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, neg, carry_out, invalid
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, neg, carry_out, invalid
  );
endinterface

// File: rtl/bcd_serial_alu.sv
// Digit-serial BCD add/subtract, one decimal digit per clock, LSD first.
// Subtraction uses 9's complement of b plus carry-in (10's complement);
// a negative outcome gets a recomplement pass so result is always a magnitude.
// Optional feature: define BCD_ALU_SAT_EN to saturate an overflowing
// addition to all 9s instead of wrapping modulo 10^DIGITS.
module bcd_serial_alu #(
  parameter int DIGITS = 4
) (
  input logic             CLOCK_50,
  input logic             RST,
  bcd_serial_alu_if.slave bus
);
  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_NEG, S_DONE} state_t;

  state_t             r_state, w_next;
  logic [W-1:0]       r_a, r_b, r_result;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry, r_sub, r_neg, r_cout, r_inv, r_done;

  logic [IDX_W+1:0]   w_sh;
  logic [W-1:0]       w_a_sh, w_b_sh, w_r_sh, w_mask, w_new_res;
  logic [3:0]         w_x, w_y;
  logic [4:0]         w_sum;
  logic               w_last_digit, w_finalize;

  // One decimal digit add with correction: returns {carry, digit}.
  function automatic logic [4:0] dec_digit_add(input logic [3:0] x,
                                               input logic [3:0] y,
                                               input logic       c);
    logic [4:0] s;
    s = {1'b0, x} + {1'b0, y} + {4'd0, c};
    if (s > 5'd9) return {1'b1, s[3:0] - 4'd10};
    else          return {1'b0, s[3:0]};
  endfunction

  function automatic logic any_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [W-1:0] nines_comp(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < DIGITS; i++) r[i*4 +: 4] = 4'd9 - v[i*4 +: 4];
    return r;
  endfunction

  function automatic logic [W-1:0] sat_value();
    logic [W-1:0] r;
    for (int i = 0; i < DIGITS; i++) r[i*4 +: 4] = 4'd9;
    return r;
  endfunction

  // Digit select, shared digit adder and result-digit merge.
  always_comb begin
    w_sh         = {r_idx, 2'b00};
    w_a_sh       = r_a >> w_sh;
    w_b_sh       = r_b >> w_sh;
    w_r_sh       = r_result >> w_sh;
    w_x          = (r_state == S_NEG) ? (4'd9 - w_r_sh[3:0]) : w_a_sh[3:0];
    w_y          = (r_state == S_NEG) ? 4'd0 : w_b_sh[3:0];
    w_sum        = dec_digit_add(w_x, w_y, r_carry);
    w_mask       = W'(4'hF) << w_sh;
    w_new_res    = (r_result & ~w_mask) | (W'(w_sum[3:0]) << w_sh);
    w_last_digit = (r_idx == IDX_W'(DIGITS - 1));
    w_finalize   = (r_idx == IDX_W'(DIGITS));
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.start) w_next = S_CALC;
      S_CALC: begin
        if (r_inv)           w_next = S_DONE;
        else if (w_finalize) w_next = (!r_sub || r_carry) ? S_DONE : S_NEG;
      end
      S_NEG:  if (w_last_digit) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State, operand, digit-walk and result/flag registers.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_sub    <= 1'b0;
      r_neg    <= 1'b0;
      r_cout   <= 1'b0;
      r_inv    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (w_next == S_DONE);
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_a      <= bus.a;
          r_b      <= bus.sub ? nines_comp(bus.b) : bus.b;
          r_carry  <= bus.sub;
          r_sub    <= bus.sub;
          r_idx    <= '0;
          r_result <= '0;
          r_neg    <= 1'b0;
          r_cout   <= 1'b0;
          r_inv    <= any_bad_digit(bus.a) | any_bad_digit(bus.b);
        end
        S_CALC: if (!r_inv) begin
          if (w_finalize) begin
            if (!r_sub) begin
              r_cout <= r_carry;
`ifdef BCD_ALU_SAT_EN
              if (r_carry) r_result <= sat_value();
`endif
            end else if (!r_carry) begin
              // No end-around carry: a < b, recomplement the 9's form.
              r_neg   <= 1'b1;
              r_idx   <= '0;
              r_carry <= 1'b1;
            end
          end else begin
            r_result <= w_new_res;
            r_carry  <= w_sum[4];
            r_idx    <= r_idx + 1'b1;
          end
        end
        S_NEG: begin
          r_result <= w_new_res;
          r_carry  <= w_sum[4];
          r_idx    <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = r_done;
  assign bus.result    = r_result;
  assign bus.neg       = r_neg;
  assign bus.carry_out = r_cout;
  assign bus.invalid   = r_inv;

endmodule
